// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: drives the input mux and DAC, reads one comparator,
// and returns one result per enabled channel, optionally averaged over 2**AVG_LOG2 conversions.
module sar_adc_scan_ctrl #(
    parameter int unsigned WIDTH             = 8,
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned SETTLE_CYCLES     = 50000,
    parameter int unsigned MUX_SETTLE_CYCLES = 1000,
    parameter int unsigned AVG_LOG2          = 0,
    localparam int unsigned CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              comp_in,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [WIDTH-1:0]  trial_code,
    output logic [CH_W-1:0]   ch_sel,
    output logic              busy,
    output logic              result_valid,
    output logic [WIDTH-1:0]  result_data,
    output logic [CH_W-1:0]   result_ch
);

    localparam int unsigned BIT_W   = $clog2(WIDTH);
    localparam int unsigned ACC_W   = WIDTH + AVG_LOG2;
    localparam int unsigned SCNT_W  = AVG_LOG2 + 1;
    localparam int unsigned NUM_AVG = 1 << AVG_LOG2;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > MUX_SETTLE_CYCLES) ?
                                      SETTLE_CYCLES : MUX_SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUX_SETTLE,
        S_SET_BIT,
        S_WAIT_SETTLE,
        S_SAMPLE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t              state_q, state_d;
    logic                comp_meta_q, comp_q;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0]    trial_q, trial_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [CH_W-1:0]     rch_q, rch_d;
    logic [CH_W:0]       next_above;

    // Lowest set bit of a channel mask.
    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (m[i]) ch = CH_W'(i);
        end
        return ch;
    endfunction

    // {found, channel} for the lowest set bit strictly above cur.
    function automatic logic [CH_W:0] next_ch(input logic [NUM_CH-1:0] m,
                                              input logic [CH_W-1:0]   cur);
        logic            found;
        logic [CH_W-1:0] ch;
        found = 1'b0;
        ch    = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) begin
                found = 1'b1;
                ch    = CH_W'(i);
            end
        end
        return {found, ch};
    endfunction

    // State and datapath registers, comparator synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            comp_meta_q <= 1'b0;
            comp_q      <= 1'b0;
            mask_q      <= '0;
            ch_q        <= '0;
            bit_q       <= '0;
            trial_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            scnt_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            rch_q       <= '0;
        end else begin
            state_q     <= state_d;
            comp_meta_q <= comp_in;
            comp_q      <= comp_meta_q;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            bit_q       <= bit_d;
            trial_q     <= trial_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            scnt_q      <= scnt_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            rch_q       <= rch_d;
        end
    end

    assign acc_sum    = acc_q + ACC_W'(trial_q);
    assign next_above = next_ch(mask_q, ch_q);

    // Next-state and datapath update; the result is registered on the way into S_OUTPUT.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        trial_d = trial_q;
        cnt_d   = '0;
        acc_d   = acc_q;
        scnt_d  = scnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        rch_d   = rch_q;

        case (state_q)
            S_IDLE: begin
                trial_d = '0;
                if (start && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    ch_d    = lowest_ch(ch_mask);
                    acc_d   = '0;
                    scnt_d  = '0;
                    bit_d   = BIT_W'(WIDTH - 1);
                    state_d = S_MUX_SETTLE;
                end
            end
            S_MUX_SETTLE: begin
                trial_d = '0;
                bit_d   = BIT_W'(WIDTH - 1);
                if (cnt_q == CNT_W'(MUX_SETTLE_CYCLES - 1)) begin
                    state_d = S_SET_BIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SET_BIT: begin
                trial_d[bit_q] = 1'b1;
                state_d        = S_WAIT_SETTLE;
            end
            S_WAIT_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (!comp_q) trial_d[bit_q] = 1'b0;
                if (bit_q != '0) begin
                    bit_d   = bit_q - BIT_W'(1);
                    state_d = S_SET_BIT;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d  = acc_sum;
                scnt_d = scnt_q + SCNT_W'(1);
                if (scnt_q == SCNT_W'(NUM_AVG - 1)) begin
                    valid_d = 1'b1;
                    data_d  = WIDTH'(acc_sum >> AVG_LOG2);
                    rch_d   = ch_q;
                    state_d = S_OUTPUT;
                end else begin
                    trial_d = '0;
                    bit_d   = BIT_W'(WIDTH - 1);
                    state_d = S_SET_BIT;
                end
            end
            S_OUTPUT: begin
                acc_d   = '0;
                scnt_d  = '0;
                trial_d = '0;
                bit_d   = BIT_W'(WIDTH - 1);
                if (next_above[CH_W]) begin
                    ch_d    = next_above[CH_W-1:0];
                    state_d = S_MUX_SETTLE;
                end else if (continuous) begin
                    ch_d    = lowest_ch(mask_q);
                    state_d = S_MUX_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign trial_code   = trial_q;
    assign ch_sel       = ch_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result_data  = data_q;
    assign result_ch    = rch_q;

endmodule

// File: tb/tb_sar_adc_scan_ctrl.sv
// Directed bench for sar_adc_scan_ctrl: dut0 without averaging, dut1 averaging two conversions.
module tb_sar_adc_scan_ctrl;

    localparam int unsigned W   = 4;
    localparam int unsigned NCH = 4;
    localparam int unsigned ST  = 3;
    localparam int unsigned MST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           start0, start1, cont0, cont1;
    logic [NCH-1:0] mask0, mask1;
    logic [W-1:0]   vin [NCH];
    logic [W-1:0]   vin_avg;

    logic           comp_in0, comp_in1;
    logic [W-1:0]   trial_code0, trial_code1, result_data0, result_data1;
    logic [1:0]     ch_sel0, ch_sel1, result_ch0, result_ch1;
    logic           busy0, busy1, result_valid0, result_valid1;

    assign comp_in0 = (vin[ch_sel0] >= trial_code0);
    assign comp_in1 = (vin_avg >= trial_code1);

    sar_adc_scan_ctrl #(.WIDTH(W), .NUM_CH(NCH), .SETTLE_CYCLES(ST),
                        .MUX_SETTLE_CYCLES(MST), .AVG_LOG2(0)) dut0 (
        .clk(clk), .reset(reset), .comp_in(comp_in0), .start(start0),
        .continuous(cont0), .ch_mask(mask0), .trial_code(trial_code0),
        .ch_sel(ch_sel0), .busy(busy0), .result_valid(result_valid0),
        .result_data(result_data0), .result_ch(result_ch0)
    );

    sar_adc_scan_ctrl #(.WIDTH(W), .NUM_CH(NCH), .SETTLE_CYCLES(ST),
                        .MUX_SETTLE_CYCLES(MST), .AVG_LOG2(1)) dut1 (
        .clk(clk), .reset(reset), .comp_in(comp_in1), .start(start1),
        .continuous(cont1), .ch_mask(mask1), .trial_code(trial_code1),
        .ch_sel(ch_sel1), .busy(busy1), .result_valid(result_valid1),
        .result_data(result_data1), .result_ch(result_ch1)
    );

    typedef struct packed {
        logic [1:0]   ch;
        logic [W-1:0] data;
    } res_t;

    res_t res0[$];
    res_t res1[$];
    bit   bad_sel;
    bit   mon_sel_en;
    int   compared;
    int   mismatched;

    // Result capture and channel-select monitor.
    initial begin
        bad_sel    = 1'b0;
        mon_sel_en = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid0 === 1'b1) res0.push_back({result_ch0, result_data0});
            if (result_valid1 === 1'b1) res1.push_back({result_ch1, result_data1});
            if (mon_sel_en && busy0 === 1'b1 && (ch_sel0 == 2'd0 || ch_sel0 == 2'd2))
                bad_sel = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // Counts busy cycles of dut0 from the current negedge until busy drops.
    task automatic wait_idle0(input int limit, output int cycles, output int valid_at,
                              output bit to);
        cycles   = 0;
        valid_at = -1;
        to       = 1'b0;
        while (busy0 === 1'b1 && !to) begin
            if (result_valid0 === 1'b1) valid_at = cycles;
            cycles++;
            if (cycles > limit) to = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        compared += 8;
        if (trial_code0 !== 4'd0) begin mismatched++; $display("FAIL reset_trial: got %0d expected 0", trial_code0); end
        if (ch_sel0 !== 2'd0) begin mismatched++; $display("FAIL reset_ch_sel: got %0d expected 0", ch_sel0); end
        if (busy0 !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        if (result_valid0 !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", result_valid0); end
        if (result_data0 !== 4'd0) begin mismatched++; $display("FAIL reset_data: got %0d expected 0", result_data0); end
        if (result_ch0 !== 2'd0) begin mismatched++; $display("FAIL reset_rch: got %0d expected 0", result_ch0); end
        if (busy1 !== 1'b0) begin mismatched++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
        if (trial_code1 !== 4'd0) begin mismatched++; $display("FAIL reset_trial1: got %0d expected 0", trial_code1); end
        reset = 1'b0;
        tick(1);
    endtask

    // One channel, one conversion: checks data, channel, latency and busy drop.
    task automatic single_conv(input string name, input logic [W-1:0] v, input int exp_cycles);
        int cyc, vat;
        bit to;
        res0.delete();
        vin[0] = v;
        mask0  = 4'b0001;
        cont0  = 1'b0;
        pulse_start0();
        wait_idle0(200, cyc, vat, to);
        compared += 4;
        if (to) begin mismatched++; $display("FAIL %s_timeout: busy still high after 200 cycles", name); end
        if (cyc != exp_cycles) begin mismatched++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_cycles); end
        if (vat != exp_cycles - 1) begin mismatched++; $display("FAIL %s_valid_at: got %0d expected %0d", name, vat, exp_cycles - 1); end
        if (res0.size() != 1) begin
            mismatched++; $display("FAIL %s_count: got %0d expected 1", name, res0.size());
        end else begin
            compared += 1;
            if (res0[0] !== {2'd0, v}) begin
                mismatched++;
                $display("FAIL %s_result: got ch%0d/%0d expected ch0/%0d", name, res0[0].ch, res0[0].data, v);
            end
        end
    endtask

    task automatic test_single();
        single_conv("single", 4'd9, 24);
    endtask

    task automatic test_two_ch();
        int cyc, vat;
        bit to;
        res0.delete();
        vin[0] = 4'd7; vin[1] = 4'd3; vin[2] = 4'd11; vin[3] = 4'd15;
        mask0 = 4'b1010;
        cont0 = 1'b0;
        bad_sel = 1'b0;
        mon_sel_en = 1'b1;
        pulse_start0();
        wait_idle0(400, cyc, vat, to);
        mon_sel_en = 1'b0;
        compared += 3;
        if (to) begin mismatched++; $display("FAIL two_ch_timeout: busy still high"); end
        if (cyc != 48) begin mismatched++; $display("FAIL two_ch_latency: got %0d expected 48", cyc); end
        if (bad_sel) begin mismatched++; $display("FAIL two_ch_sel: got ch_sel 0 or 2 expected only 1 or 3"); end
        compared += 1;
        if (res0.size() != 2) begin
            mismatched++; $display("FAIL two_ch_count: got %0d expected 2", res0.size());
        end else begin
            compared += 2;
            if (res0[0] !== {2'd1, 4'd3}) begin mismatched++; $display("FAIL two_ch_r0: got ch%0d/%0d expected ch1/3", res0[0].ch, res0[0].data); end
            if (res0[1] !== {2'd3, 4'd15}) begin mismatched++; $display("FAIL two_ch_r1: got ch%0d/%0d expected ch3/15", res0[1].ch, res0[1].data); end
        end
    endtask

    // dut1 averages two conversions; vin changes during the first S_ACCUM (cycle 22).
    task automatic avg_conv(input string name, input logic [W-1:0] v1, input logic [W-1:0] v2,
                            input logic [W-1:0] exp_data);
        int cyc;
        res1.delete();
        vin_avg = v1;
        mask1   = 4'b0001;
        start1  = 1'b1;
        @(negedge clk);
        start1  = 1'b0;
        cyc = 0;
        while (busy1 === 1'b1 && cyc <= 200) begin
            if (cyc == 22) vin_avg = v2;
            cyc++;
            @(negedge clk);
        end
        compared += 2;
        if (cyc != 45) begin mismatched++; $display("FAIL %s_latency: got %0d expected 45", name, cyc); end
        if (res1.size() != 1) begin
            mismatched++; $display("FAIL %s_count: got %0d expected 1", name, res1.size());
        end else begin
            compared += 1;
            if (res1[0] !== {2'd0, exp_data}) begin
                mismatched++;
                $display("FAIL %s_result: got ch%0d/%0d expected ch0/%0d", name, res1[0].ch, res1[0].data, exp_data);
            end
        end
    endtask

    task automatic test_avg();
        avg_conv("avg_6_7", 4'd6, 4'd7, 4'd6);
        avg_conv("avg_3_12", 4'd3, 4'd12, 4'd7);
    endtask

    task automatic test_continuous();
        int cyc, vat, n;
        bit to;
        res0.delete();
        vin[0] = 4'd5; vin[1] = 4'd1; vin[2] = 4'd10; vin[3] = 4'd2;
        mask0 = 4'b0101;
        cont0 = 1'b1;
        pulse_start0();
        n = 0;
        while (res0.size() < 2 && n < 200) begin
            n++;
            @(negedge clk);
        end
        tick(3);
        cont0 = 1'b0;
        wait_idle0(400, cyc, vat, to);
        compared += 2;
        if (to) begin mismatched++; $display("FAIL cont_timeout: busy still high"); end
        if (res0.size() != 4) begin
            mismatched++; $display("FAIL cont_count: got %0d expected 4", res0.size());
        end else begin
            compared += 4;
            if (res0[0] !== {2'd0, 4'd5})  begin mismatched++; $display("FAIL cont_r0: got ch%0d/%0d expected ch0/5", res0[0].ch, res0[0].data); end
            if (res0[1] !== {2'd2, 4'd10}) begin mismatched++; $display("FAIL cont_r1: got ch%0d/%0d expected ch2/10", res0[1].ch, res0[1].data); end
            if (res0[2] !== {2'd0, 4'd5})  begin mismatched++; $display("FAIL cont_r2: got ch%0d/%0d expected ch0/5", res0[2].ch, res0[2].data); end
            if (res0[3] !== {2'd2, 4'd10}) begin mismatched++; $display("FAIL cont_r3: got ch%0d/%0d expected ch2/10", res0[3].ch, res0[3].data); end
        end
    endtask

    task automatic test_boundary();
        int cyc, vat;
        bit to;
        single_conv("vin_zero", 4'd0, 24);
        single_conv("vin_full", 4'd15, 24);
        // start with an empty mask
        mask0 = 4'b0000;
        pulse_start0();
        compared += 1;
        if (busy0 !== 1'b0) begin mismatched++; $display("FAIL mask0_busy_now: got %b expected 0", busy0); end
        tick(5);
        compared += 1;
        if (busy0 !== 1'b0) begin mismatched++; $display("FAIL mask0_busy_later: got %b expected 0", busy0); end
        // start and mask change while busy
        res0.delete();
        vin[0] = 4'd9; vin[1] = 4'd4; vin[2] = 4'd8; vin[3] = 4'd12;
        mask0 = 4'b0001;
        pulse_start0();
        tick(5);
        mask0 = 4'b1111;
        pulse_start0();
        wait_idle0(200, cyc, vat, to);
        compared += 2;
        if (cyc != 18) begin mismatched++; $display("FAIL busy_start_latency: got %0d expected 18", cyc); end
        if (res0.size() != 1) begin
            mismatched++; $display("FAIL busy_start_count: got %0d expected 1", res0.size());
        end else begin
            compared += 1;
            if (res0[0] !== {2'd0, 4'd9}) begin mismatched++; $display("FAIL busy_start_result: got ch%0d/%0d expected ch0/9", res0[0].ch, res0[0].data); end
        end
    endtask

    task automatic test_reset_mid();
        res0.delete();
        vin[0] = 4'd9;
        mask0  = 4'b0001;
        cont0  = 1'b0;
        pulse_start0();
        tick(4);
        compared += 2;
        if (busy0 !== 1'b1) begin mismatched++; $display("FAIL mid_busy: got %b expected 1", busy0); end
        if (trial_code0 !== 4'd8) begin mismatched++; $display("FAIL mid_trial: got %0d expected 8", trial_code0); end
        reset = 1'b1;
        @(negedge clk);
        compared += 6;
        if (trial_code0 !== 4'd0) begin mismatched++; $display("FAIL rmid_trial: got %0d expected 0", trial_code0); end
        if (ch_sel0 !== 2'd0) begin mismatched++; $display("FAIL rmid_ch_sel: got %0d expected 0", ch_sel0); end
        if (busy0 !== 1'b0) begin mismatched++; $display("FAIL rmid_busy: got %b expected 0", busy0); end
        if (result_valid0 !== 1'b0) begin mismatched++; $display("FAIL rmid_valid: got %b expected 0", result_valid0); end
        if (result_data0 !== 4'd0) begin mismatched++; $display("FAIL rmid_data: got %0d expected 0", result_data0); end
        if (result_ch0 !== 2'd0) begin mismatched++; $display("FAIL rmid_rch: got %0d expected 0", result_ch0); end
        reset = 1'b0;
        tick(1);
        single_conv("after_reset", 4'd12, 24);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset   = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        cont0   = 1'b0;
        cont1   = 1'b0;
        mask0   = '0;
        mask1   = '0;
        vin_avg = '0;
        for (int i = 0; i < int'(NCH); i++) vin[i] = '0;

        test_reset();
        test_single();
        test_two_ch();
        test_avg();
        test_continuous();
        test_boundary();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
